// File: rtl/neuron_mac.sv
// Single-neuron MAC sequencer: streams weights from a negedge-sampled block ROM, accumulates
// x*w, adds the trailing bias word and saturates. Define NEURON_RELU_EN for ReLU output.
module neuron_mac #(
    parameter int unsigned N     = 8,
    parameter int unsigned Q     = 7,
    parameter int unsigned ACC_W = 2 * N + 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   base_addr,
    input  logic [7:0]   count,
    input  logic [N-1:0] x_in,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [7:0]   w_addr,
    input  logic [N-1:0] w_data,
    output logic [N-1:0] y_out,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StMac, StBias, StOut} state_e;

    state_e                   state_q, state_d;
    logic [7:0]               w_addr_q, w_addr_d;
    logic [7:0]               idx_q, idx_d;
    logic [7:0]               count_q, count_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [N-1:0]             y_out_q, y_out_d;

    logic signed [2*N-1:0]    prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_bias;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [ACC_W-N:0]         shr_hi;
    logic [N-1:0]             sat;
    logic [N-1:0]             act;

    assign prod     = $signed(x_in) * $signed(w_data);
    assign prod_ext = {{(ACC_W - 2 * N){prod[2*N-1]}}, prod};
    // Bias is Q-format; align it to the 2Q-fraction accumulator.
    assign bias_ext = {{(ACC_W - N - Q){w_data[N-1]}}, w_data, {Q{1'b0}}};
    assign acc_bias = acc_q + bias_ext;
    assign acc_shr  = acc_bias >>> Q;
    assign shr_hi   = acc_shr[ACC_W-1:N-1];

    always_comb begin
        sat = acc_shr[N-1:0];
        // In range only if every bit from the sign of the N-bit result upward agrees.
        if (!((&shr_hi) || (~|shr_hi))) begin
            sat = acc_shr[ACC_W-1] ? {1'b1, {(N - 1){1'b0}}} : {1'b0, {(N - 1){1'b1}}};
        end
    end

`ifdef NEURON_RELU_EN
    assign act = sat[N-1] ? '0 : sat;
`else
    assign act = sat;
`endif

    always_comb begin
        state_d  = state_q;
        w_addr_d = w_addr_q;
        idx_d    = idx_q;
        count_d  = count_q;
        acc_d    = acc_q;
        y_out_d  = y_out_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d  = count;
                    w_addr_d = base_addr;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = (count != 8'd0) ? StMac : StBias;
                end
            end
            StMac: begin
                if (x_valid) begin
                    acc_d    = acc_q + prod_ext;
                    w_addr_d = w_addr_q + 8'd1;
                    idx_d    = idx_q + 8'd1;
                    if (idx_q == count_q - 8'd1) begin
                        state_d = StBias;
                    end
                end
            end
            StBias: begin
                acc_d   = acc_bias;
                y_out_d = act;
                state_d = StOut;
            end
            StOut: begin
                if (y_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            w_addr_q <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            y_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            w_addr_q <= w_addr_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            y_out_q  <= y_out_d;
        end
    end

    assign x_ready = (state_q == StMac);
    assign y_valid = (state_q == StOut);
    assign busy    = (state_q != StIdle);
    assign w_addr  = w_addr_q;
    assign y_out   = y_out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed runs push expected results, a negedge monitor
// pops and checks value and latency on each output handshake.
module tb_neuron_mac;

    logic       clk = 1'b0;
    logic       rst, start, x_valid, x_ready, y_valid, y_ready, busy;
    logic [7:0] base_addr, count, x_in, w_addr, w_data, y_out;
    logic [7:0] rom [256];

    typedef struct {
        int y;
        int lat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pcyc  = 0;
    bit   seen  = 1'b0;
    int   first_cyc;
    logic [7:0] held;

`ifdef NEURON_RELU_EN
    localparam bit Relu = 1'b1;
`else
    localparam bit Relu = 1'b0;
`endif

    always #5 clk = ~clk;

    neuron_mac #(.N(8), .Q(7), .ACC_W(25)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .busy      (busy)
    );

    // Block ROM samples the address on the falling edge.
    always @(negedge clk) w_data <= rom[w_addr];
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (y_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_y_valid", 1, 0);
            end else begin
                exp_t e;
                if (!seen) begin
                    seen      = 1'b1;
                    first_cyc = pcyc;
                    held      = y_out;
                end else begin
                    chk("y_out_stable", int'($signed(y_out)), int'($signed(held)));
                end
                if (y_ready) begin
                    e = sb.pop_front();
                    chk("y_out", int'($signed(y_out)), e.y);
                    chk("latency", first_cyc - e.cyc, e.lat);
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] c, input int ey,
                            input int elat, input bit push);
        exp_t e;
        start     = 1'b1;
        base_addr = b;
        count     = c;
        if (push) begin
            e.y   = ey;
            e.lat = elat;
            e.cyc = pcyc;
            sb.push_back(e);
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x_valid = 1'b1; y_ready = 1'b1;
        x_in = '0; base_addr = '0; count = '0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[10] = 8'd64;  rom[11] = 8'd64;  rom[12] = 8'd0;
        for (int i = 20; i < 25; i++) rom[i] = 8'd127;
        rom[30] = 8'h80;  rom[31] = 8'h80;  rom[32] = 8'h80;
        rom[40] = 8'd64;
        for (int i = 60; i < 64; i++) rom[i] = 8'd32;
        rom[100] = 8'hFF; rom[101] = 8'h00;
        rom[254] = 8'd64; rom[255] = 8'd64; rom[0] = 8'd64; rom[1] = 8'hE0;

        repeat (3) step();
        chk("rst_w_addr", w_addr, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Basic MAC: 64*64 + 64*64 + 0 -> 64
        x_in = 8'd64;
        do_start(8'd10, 8'd2, 64, 4, 1'b1);
        chk("basic_addr0", w_addr, 10);
        chk("basic_x_ready", x_ready, 1);
        step(); chk("basic_addr1", w_addr, 11);
        step(); chk("basic_addr2", w_addr, 12);
        wait_done();

        // Positive saturation with 5 cycles of backpressure; start must be ignored.
        y_ready = 1'b0;
        x_in = 8'd127;
        do_start(8'd20, 8'd4, 127, 6, 1'b1);
        for (int i = 0; i < 20 && !y_valid; i++) step();
        chk("bp_valid", y_valid, 1);
        start = 1'b1; base_addr = 8'd40; count = 8'd0;
        repeat (5) begin
            step();
            chk("bp_busy", busy, 1);
            chk("bp_valid_hold", y_valid, 1);
        end
        start = 1'b0; y_ready = 1'b1;
        step();
        chk("bp_idle", busy, 0);
        chk("bp_drop", y_valid, 0);
        wait_done();

        // Negative saturation (ReLU clamps to 0).
        x_in = 8'd127;
        do_start(8'd30, 8'd2, Relu ? 0 : -128, 4, 1'b1);
        wait_done();

        // Stalls: x_valid 1,0,0,1 adds two cycles.
        x_in = 8'd64;
        do_start(8'd10, 8'd2, 64, 6, 1'b1);
        step(); x_valid = 1'b0;
        chk("stall_addr_a", w_addr, 11);
        step();
        chk("stall_addr_b", w_addr, 11);
        chk("stall_x_ready", x_ready, 1);
        step(); x_valid = 1'b1;
        wait_done();

        // Bias only.
        do_start(8'd40, 8'd0, 64, 2, 1'b1);
        wait_done();

        // Address wrap: 3*64*64 - 32<<7 -> 64
        x_in = 8'd64;
        do_start(8'd254, 8'd3, 64, 5, 1'b1);
        chk("wrap_addr0", w_addr, 254);
        step(); chk("wrap_addr1", w_addr, 255);
        step(); chk("wrap_addr2", w_addr, 0);
        step(); chk("wrap_bias", w_addr, 1);
        wait_done();

        // Arithmetic shift floors: -1 (2Q) >>> 7 -> -1
        x_in = 8'd1;
        do_start(8'd100, 8'd1, Relu ? 0 : -1, 3, 1'b1);
        wait_done();

        // Reset after the second of four transfers aborts without output.
        x_in = 8'd64;
        do_start(8'd60, 8'd4, 0, 0, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_w_addr", w_addr, 0);
        chk("abort_y_out", y_out, 0);
        chk("abort_y_valid", y_valid, 0);
        chk("abort_x_ready", x_ready, 0);
        chk("abort_busy", busy, 0);
        do_start(8'd60, 8'd4, 64, 6, 1'b1);
        wait_done();

        // Start coincident with reset is ignored.
        rst = 1'b1; start = 1'b1; base_addr = 8'd40; count = 8'd0;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        step();
        chk("rst_start_busy2", busy, 0);
        chk("rst_start_valid", y_valid, 0);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Single-neuron multiply-accumulate sequencer that drives the address port of the block-ROM weight store and consumes its registered output. It fetches one weight per cycle, multiplies it against a streamed input activation, and adds a bias word stored after the weights. It saturates the Q-format result and hands it downstream over a valid/ready handshake. One instance sits between the input-activation stream and the next layer's input buffer.

## Interface
- `N`, 8: signed word width of weights, activations and result.
- `Q`, 7: fractional bits (signed Q(N-1-Q).Q).
- `ACC_W`, 2*N+9: accumulator width. Must be ≥ 2N+9 so that 256 full-scale products plus the bias cannot overflow.
- `clk` input 1: single clock. All state updates on posedge. The weight ROM samples `w_addr` on negedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin one neuron evaluation. Sampled only in IDLE.
- `base_addr` input 8: ROM address of the first weight. Latched on start.
- `count` input 8: number of inputs, 0–255. Latched on start.
- `x_in` input N signed: input activation.
- `x_valid` input 1: `x_in` is valid.
- `x_ready` output 1: the block accepts `x_in` this cycle.
- `w_addr` output 8: weight ROM address. Registered.
- `w_data` input N signed: weight ROM output, `rom[w_addr]`, valid at the posedge following an address change.
- `y_out` output N signed: saturated neuron output.
- `y_valid` output 1: `y_out` is valid.
- `y_ready` input 1: downstream accepts `y_out`.
- `busy` output 1: high in any state other than IDLE.

## Operation
States: IDLE, MAC, BIAS, OUT.

- **IDLE**
  - On `start`: latch `count`; set `w_addr` to `base_addr`, `acc` to 0, `idx` to 0.
  - Go to MAC if `count` ≠ 0. If `count` = 0, set `w_addr` to `base_addr` and go to BIAS.
- **MAC**
  - `x_ready` = 1 (combinational from state).
  - On a cycle with `x_valid`:
    - `acc` += sign-extended `x_in`·`w_data` (a 2N-bit product with 2Q fractional bits).
    - `w_addr` += 1, mod 256.
    - `idx` += 1.
  - When `idx` reaches `count`-1 on a transfer, go to BIAS. At that point `w_addr` holds `base_addr`+`count` (mod 256), the bias location.
  - With `x_valid` low: hold all state. `w_addr` stays stable.
- **BIAS**
  - `acc` += sign-extended `w_data` << Q. Go to OUT.
  - The same posedge registers `y_out` = sat_N(`acc_next` >>> Q).
- **OUT**
  - `y_valid` = 1; `y_out` holds its value.
  - On `y_ready`, go to IDLE; `y_valid` drops the next cycle.
- **Arithmetic**
  - The shift is arithmetic, truncating toward −∞.
  - Saturation clamps to [−2^(N−1), 2^(N−1)−1].
- **Boundary conditions**
  - `start` outside IDLE is ignored.
  - `start` coincident with `rst` is ignored.
  - Address wrap past 255 continues at 0.
  - `x_valid` with `x_ready` low is not consumed.
  - `rst` mid-evaluation aborts the evaluation; the next cycle is IDLE and no output is produced.
- **Reset values:** `w_addr` = 0, `y_out` = 0, `y_valid` = 0, `x_ready` = 0, `busy` = 0, `acc` = 0, state IDLE.

## Timing
- ROM latency: an address registered at posedge t is read at the negedge in cycle t, so `w_data` is valid at posedge t+1. This permits one MAC per cycle with no bubbles.
- With `x_valid` held high, `y_valid` rises `count`+2 cycles after the posedge that samples `start`.
  - `count` = 0 gives 2 cycles.
  - Each cycle `x_valid` is low adds one cycle.
- Handshakes:
  - `x_ready` and `y_valid` depend only on state, not combinationally on `x_valid` or `y_ready`.
  - A transfer occurs on any posedge where valid and ready are both high.
- Back-to-back operation: `start` may be asserted in the cycle after the OUT handshake.

## Configuration
- `NEURON_RELU_EN` defined: `y_out` = 0 whenever the saturated result is negative. Applied in the same BIAS cycle, with no added latency.
- `NEURON_RELU_EN` undefined: `y_out` is the signed saturated value (linear activation).

## Test plan
- **Basic MAC:** ROM[10,11,12] = 64, 64, 0; `base_addr` = 10, `count` = 2; `x_in` = 64, 64 with `x_valid` continuous.
  - `w_addr` steps 10, 11, 12.
  - `y_out` = 64 with `y_valid` 4 cycles after `start`.
- **Saturation:** `count` = 4; weights 127; `x_in` = 127; bias 127 → `y_out` = 127.
  - Weights −128, `x_in` = 127, `count` = 2, bias −128 → `y_out` = −128, or 0 with `NEURON_RELU_EN`.
- **Stalls and backpressure:** `x_valid` toggled 1, 0, 0, 1 for `count` = 2 → result identical to Basic MAC, `y_valid` 2 cycles later.
  - `y_ready` held low 5 cycles → `y_out` stable and `start` ignored throughout.
- **Bias only and wrap:** `count` = 0, `base_addr` = 40, ROM[40] = 64 → `y_out` = 64 after 2 cycles.
  - `base_addr` = 254, `count` = 3 → `w_addr` sequence 254, 255, 0, then bias at 1.
- **Mid-operation reset:** `rst` after the second of 4 MAC transfers → next cycle all outputs at reset values, no `y_valid`.
  - A fresh `start` then produces the correct result from `acc` = 0.
